// File: rtl/tb_queue_arbiter.sv
// tb_queue_arbiter
//   Shares one downstream valid/ready sink between NUM_SRC stimulus queues.
//   One beat per grant, round-robin between grants, data held under
//   backpressure. Per-source finish flags fold into one sticky finish, and a
//   stall watchdog flags a sink that stops taking data.
// Ports
//   clk, reset     clock and synchronous active-high reset
//   src_dvld_i     per-source valid
//   src_ddat_i     per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_finish_i   per-source finished flag
//   src_drdy_o     per-source ready, only the granted source can see it high
//   dvld_o/ddat_o  downstream beat, drdy_i downstream ready
//   grant_o        one-hot grant while a beat is in flight
//   beat_count_o   completed downstream handshakes (wraps)
//   finish_o       sticky: every source finished and nothing in flight
//   timeout_o      sticky: sink stalled TIMEOUT_CYCLES consecutive cycles
//   proto_err_o    sticky: granted source dropped valid before handshake

// Per-source lane: gates one source onto the shared sink when selected.
module tb_queue_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_sel,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_drdy,
  output logic                  o_vld,
  output logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_dat
);
  assign o_vld = i_sel & i_vld;
  // Ready only while valid: a queue source pops on ready alone, so a ready
  // without valid would silently drop the next entry.
  assign o_rdy = o_vld & i_drdy;
  assign o_dat = i_sel ? i_dat : '0;
endmodule

module tb_queue_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_dvld_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_ddat_i,
  input  logic [NUM_SRC-1:0]            src_finish_i,
  output logic [NUM_SRC-1:0]            src_drdy_o,
  output logic                          dvld_o,
  output logic [DATA_WIDTH-1:0]         ddat_o,
  input  logic                          drdy_i,
  output logic [NUM_SRC-1:0]            grant_o,
  output logic [31:0]                   beat_count_o,
  output logic                          finish_o,
  output logic                          timeout_o,
  output logic                          proto_err_o
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_DONE} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_gidx;
  logic [IW-1:0]       r_rr_ptr;
  logic [NUM_SRC-1:0]  r_grant;
  logic [31:0]         r_beats;
  logic [31:0]         r_stall;
  logic                r_fin;
  logic                r_to;
  logic                r_pe;

  logic                w_locked;
  logic                w_gvld;
  logic                w_pick_vld;
  logic [IW-1:0]       w_pick;
  logic [NUM_SRC-1:0]  w_sel;
  logic [NUM_SRC-1:0]  w_lane_vld;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] w_lane_dat;

  // Reset gates the datapath combinationally so a mid-beat reset drops
  // valid/ready in the same cycle, before the state register clears.
  assign w_locked = (r_state == S_LOCKED) & ~reset;
  assign w_sel    = r_grant & {NUM_SRC{w_locked}};
  assign w_gvld   = |(src_dvld_i & r_grant);

  tb_queue_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [NUM_SRC-1:0] (
    .i_sel  (w_sel),
    .i_vld  (src_dvld_i),
    .i_dat  (src_ddat_i),
    .i_drdy (drdy_i),
    .o_vld  (w_lane_vld),
    .o_rdy  (src_drdy_o),
    .o_dat  (w_lane_dat)
  );

  assign dvld_o = |w_lane_vld;

  always_comb begin
    ddat_o = '0;
    for (int i = 0; i < NUM_SRC; i++) ddat_o = ddat_o | w_lane_dat[i];
  end

  // Round-robin: scan indices above the last winner first, then wrap.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (!w_pick_vld && src_dvld_i[i] && i > int'(r_rr_ptr)) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'(i);
      end
    for (int i = 0; i < NUM_SRC; i++)
      if (!w_pick_vld && src_dvld_i[i] && i <= int'(r_rr_ptr)) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'(i);
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gidx   <= '0;
      r_rr_ptr <= IW'(NUM_SRC - 1);
      r_grant  <= '0;
      r_beats  <= '0;
      r_stall  <= '0;
      r_fin    <= 1'b0;
      r_to     <= 1'b0;
      r_pe     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_gidx  <= w_pick;
            r_grant <= NUM_SRC'(1) << w_pick;
            r_state <= S_LOCKED;
          end else if (&src_finish_i) begin
            r_fin   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_LOCKED: begin
          if (!w_gvld) begin
            // Source withdrew its beat: nothing was transferred.
            r_pe    <= 1'b1;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (drdy_i) begin
            r_beats  <= r_beats + 32'd1;
            r_rr_ptr <= r_gidx;
            r_stall  <= '0;
            r_grant  <= '0;
            r_state  <= S_IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            // Counter saturates at the threshold; the flag is sticky.
            if (r_stall >= TO_LAST) r_to    <= 1'b1;
            else                    r_stall <= r_stall + 32'd1;
          end
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_o      = r_grant;
  assign beat_count_o = r_beats;
  assign finish_o     = r_fin;
  assign timeout_o    = r_to;
  assign proto_err_o  = r_pe;
endmodule
